// File: rtl/ppu_pkg.sv
// ppu_pkg: definitions shared between the PPU and its frame sink.
//   LCD_WIDTH / LCD_HEIGHT : visible LCD geometry
//   sink_state_e           : frame sink FSM states
//   palette_map()          : maps a 2-bit shade through a BGP-style palette
package ppu_pkg;

    localparam int unsigned LCD_WIDTH  = 160;
    localparam int unsigned LCD_HEIGHT = 144;

    typedef enum logic [1:0] {
        StSync,  // waiting for the first vblank after reset
        StLine,  // accepting pixels of the current line
        StHold,  // line full, waiting for hblank
        StFull   // frame full, waiting for vblank
    } sink_state_e;

    // Colour for a shade is bgp[2*shade+1 : 2*shade].
    function automatic logic [1:0] palette_map(input logic [1:0] shade, input logic [7:0] bgp);
        logic [1:0] colour;
        unique case (shade)
            2'd0: colour = bgp[1:0];
            2'd1: colour = bgp[3:2];
            2'd2: colour = bgp[5:4];
            2'd3: colour = bgp[7:6];
            default: colour = bgp[1:0];
        endcase
        return colour;
    endfunction

endpackage

// File: rtl/fb_line_tracker.sv
// fb_line_tracker: pixel/line position and framebuffer offset generation.
//   clk_in, rst_n_in     : clock, asynchronous active-low reset
//   pix_accept_in        : a pixel is written at the current position this cycle
//   line_adv_in          : advance to the next line (x = 0, y + 1, line_base + WIDTH)
//   frame_clr_in         : restart the frame (x = y = line_base = 0); wins over the others
//   pix_addr_out         : in-bank offset line_base + x of the current pixel
//   line_out             : current line index y
//   last_pix_out         : x is the last pixel position of the line
//   last_line_out        : y is the last visible line (advancing completes the frame)
//   at_height_out        : y == HEIGHT, every visible line has been advanced past
module fb_line_tracker
    import ppu_pkg::*;
#(
    parameter int unsigned WIDTH  = LCD_WIDTH,
    parameter int unsigned HEIGHT = LCD_HEIGHT,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              pix_accept_in,
    input  logic              line_adv_in,
    input  logic              frame_clr_in,
    output logic [ADDR_W-2:0] pix_addr_out,
    output logic [7:0]        line_out,
    output logic              last_pix_out,
    output logic              last_line_out,
    output logic              at_height_out
);

    localparam int unsigned XW = $clog2(WIDTH + 1);
    localparam int unsigned AW = ADDR_W - 1;

    localparam logic [XW-1:0] XLast  = XW'(WIDTH - 1);
    localparam logic [7:0]    YLast  = 8'(HEIGHT - 1);
    localparam logic [7:0]    YEnd   = 8'(HEIGHT);
    localparam logic [AW-1:0] LineSz = AW'(WIDTH);

    logic [XW-1:0] x_q, x_d;
    logic [7:0]    y_q, y_d;
    logic [AW-1:0] line_base_q, line_base_d;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            x_q         <= '0;
            y_q         <= '0;
            line_base_q <= '0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            line_base_q <= line_base_d;
        end
    end

    // line_base steps by WIDTH per line, so no multiplier is needed for y*WIDTH.
    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        line_base_d = line_base_q;
        if (frame_clr_in) begin
            x_d         = '0;
            y_d         = '0;
            line_base_d = '0;
        end else if (line_adv_in) begin
            x_d         = '0;
            y_d         = y_q + 8'd1;
            line_base_d = line_base_q + LineSz;
        end else if (pix_accept_in) begin
            x_d = x_q + XW'(1);
        end
    end

    assign pix_addr_out  = line_base_q + AW'(x_q);
    assign line_out      = y_q;
    assign last_pix_out  = (x_q == XLast);
    assign last_line_out = (y_q == YLast);
    assign at_height_out = (y_q == YEnd);

endmodule

// File: rtl/ppu_frame_sink.sv
// ppu_frame_sink: consumer end of the PPU pixel stream.
// Palette-maps each accepted pixel and writes it into a double-buffered framebuffer,
// swapping banks at every vblank and flagging line/frame protocol violations.
//   clk_in, rst_n_in     : clock, asynchronous active-low reset
//   pix_valid_in         : pixel presented this cycle, shade on pix_shade_in
//   hblank_in            : one-cycle strobe, current line finished
//   vblank_in            : one-cycle strobe, frame finished
//   bgp_in               : background palette
//   clr_err_in           : clears the sticky error flags
//   fb_we_out/addr/data  : registered framebuffer write port, addr = {bank, line_base + x}
//   fb_bank_out          : bank being written; scan-out reads the other one
//   frame_done_out       : one-cycle pulse after each bank swap
//   line_out             : current line index
//   err_*_out            : sticky underrun / overflow / short-frame flags
module ppu_frame_sink
    import ppu_pkg::*;
#(
    parameter int unsigned WIDTH  = LCD_WIDTH,
    parameter int unsigned HEIGHT = LCD_HEIGHT,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              pix_valid_in,
    input  logic [1:0]        pix_shade_in,
    input  logic              hblank_in,
    input  logic              vblank_in,
    input  logic [7:0]        bgp_in,
    input  logic              clr_err_in,
    output logic              fb_we_out,
    output logic [ADDR_W-1:0] fb_addr_out,
    output logic [1:0]        fb_data_out,
    output logic              fb_bank_out,
    output logic              frame_done_out,
    output logic [7:0]        line_out,
    output logic              err_underrun_out,
    output logic              err_overflow_out,
    output logic              err_short_frame_out
);

    sink_state_e state_q, state_d;

    logic [ADDR_W-2:0] pix_addr;
    logic              last_pix;
    logic              last_line;
    logic              at_height;

    // Decoded per-cycle events
    logic pix_accept;
    logic line_full;
    logic line_adv;
    logic frame_end;
    logic frame_clr;
    logic underrun_set;
    logic overflow_set;
    logic short_set;

    logic              fb_we_q;
    logic [ADDR_W-1:0] fb_addr_q;
    logic [1:0]        fb_data_q;
    logic              bank_q;
    logic              frame_done_q;
    logic              err_underrun_q;
    logic              err_overflow_q;
    logic              err_short_frame_q;

    fb_line_tracker #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .ADDR_W (ADDR_W)
    ) u_tracker (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .pix_accept_in (pix_accept),
        .line_adv_in   (line_adv),
        .frame_clr_in  (frame_clr),
        .pix_addr_out  (pix_addr),
        .line_out      (line_out),
        .last_pix_out  (last_pix),
        .last_line_out (last_line),
        .at_height_out (at_height)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= StSync;
        end else begin
            state_q <= state_d;
        end
    end

    // Same-cycle events take effect in the order pixel, hblank, vblank.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StSync: begin
                if (vblank_in) state_d = StLine;
            end
            StLine: begin
                if (vblank_in)      state_d = StLine;
                else if (hblank_in) state_d = last_line ? StFull : StLine;
                else if (line_full) state_d = StHold;
            end
            StHold: begin
                if (vblank_in)      state_d = StLine;
                else if (hblank_in) state_d = last_line ? StFull : StLine;
            end
            StFull: begin
                if (vblank_in) state_d = StLine;
            end
            default: state_d = StSync;
        endcase
    end

    always_comb begin
        pix_accept   = pix_valid_in && (state_q == StLine);
        line_full    = pix_accept && last_pix;
        line_adv     = hblank_in && ((state_q == StLine) || (state_q == StHold));
        // A pixel completing the line in the same cycle as hblank is not an underrun.
        underrun_set = hblank_in && (state_q == StLine) && !line_full;
        overflow_set = pix_valid_in && ((state_q == StHold) || (state_q == StFull));
        frame_end    = vblank_in && (state_q != StSync);
        frame_clr    = vblank_in;
        // y is checked after any same-cycle hblank advance.
        short_set    = frame_end && (line_adv ? !last_line : !at_height);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            fb_we_q           <= 1'b0;
            fb_addr_q         <= '0;
            fb_data_q         <= '0;
            bank_q            <= 1'b0;
            frame_done_q      <= 1'b0;
            err_underrun_q    <= 1'b0;
            err_overflow_q    <= 1'b0;
            err_short_frame_q <= 1'b0;
        end else begin
            fb_we_q <= pix_accept;
            if (pix_accept) begin
                fb_addr_q <= {bank_q, pix_addr};
                fb_data_q <= palette_map(pix_shade_in, bgp_in);
            end
            if (frame_end) bank_q <= ~bank_q;
            frame_done_q      <= frame_end;
            // Set wins over a simultaneous clear.
            err_underrun_q    <= (err_underrun_q & ~clr_err_in) | underrun_set;
            err_overflow_q    <= (err_overflow_q & ~clr_err_in) | overflow_set;
            err_short_frame_q <= (err_short_frame_q & ~clr_err_in) | short_set;
        end
    end

    assign fb_we_out           = fb_we_q;
    assign fb_addr_out         = fb_addr_q;
    assign fb_data_out         = fb_data_q;
    assign fb_bank_out         = bank_q;
    assign frame_done_out      = frame_done_q;
    assign err_underrun_out    = err_underrun_q;
    assign err_overflow_out    = err_overflow_q;
    assign err_short_frame_out = err_short_frame_q;

endmodule

// File: tb/tb_ppu_frame_sink.sv
// tb_ppu_frame_sink: randomized stimulus checked every cycle against a position-based
// reference model (x/y counters and addr = bank*2^(ADDR_W-1) + y*WIDTH + x).
module tb_ppu_frame_sink;

    localparam int W  = 160;
    localparam int H  = 144;
    localparam int AW = 16;

    logic          clk_in = 1'b0;
    logic          rst_n_in = 1'b0;
    logic          pix_valid_in = 1'b0;
    logic [1:0]    pix_shade_in = '0;
    logic          hblank_in = 1'b0;
    logic          vblank_in = 1'b0;
    logic [7:0]    bgp_in = '0;
    logic          clr_err_in = 1'b0;
    logic          fb_we_out;
    logic [AW-1:0] fb_addr_out;
    logic [1:0]    fb_data_out;
    logic          fb_bank_out;
    logic          frame_done_out;
    logic [7:0]    line_out;
    logic          err_underrun_out;
    logic          err_overflow_out;
    logic          err_short_frame_out;

    ppu_frame_sink #(
        .WIDTH  (W),
        .HEIGHT (H),
        .ADDR_W (AW)
    ) dut (
        .clk_in              (clk_in),
        .rst_n_in            (rst_n_in),
        .pix_valid_in        (pix_valid_in),
        .pix_shade_in        (pix_shade_in),
        .hblank_in           (hblank_in),
        .vblank_in           (vblank_in),
        .bgp_in              (bgp_in),
        .clr_err_in          (clr_err_in),
        .fb_we_out           (fb_we_out),
        .fb_addr_out         (fb_addr_out),
        .fb_data_out         (fb_data_out),
        .fb_bank_out         (fb_bank_out),
        .frame_done_out      (frame_done_out),
        .line_out            (line_out),
        .err_underrun_out    (err_underrun_out),
        .err_overflow_out    (err_overflow_out),
        .err_short_frame_out (err_short_frame_out)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    bit m_sync;
    int m_x, m_y, m_bank;
    bit m_we, m_fd, m_und, m_ovf, m_sht;
    int m_addr, m_data;

    task automatic chk_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_sync = 0; m_x = 0; m_y = 0; m_bank = 0;
        m_we = 0; m_fd = 0; m_und = 0; m_ovf = 0; m_sht = 0;
        m_addr = 0; m_data = 0;
    endtask

    task automatic model_clock(input bit v, input int s, input bit h, input bit vb,
                               input int bgp, input bit clr);
        bit und = 0, ovf = 0, sht = 0;
        m_we = 0;
        m_fd = 0;
        if (m_sync) begin
            if (v) begin
                if (m_y < H && m_x < W) begin
                    m_we   = 1;
                    m_addr = m_bank * (1 << (AW - 1)) + m_y * W + m_x;
                    m_data = (bgp >> (2 * s)) & 3;
                    m_x++;
                end else begin
                    ovf = 1;
                end
            end
            if (h && m_y < H) begin
                if (m_x < W) und = 1;
                m_x = 0;
                m_y++;
            end
            if (vb) begin
                if (m_y != H) sht = 1;
                m_bank ^= 1;
                m_fd = 1;
                m_x  = 0;
                m_y  = 0;
            end
        end else if (vb) begin
            m_sync = 1;
            m_x = 0;
            m_y = 0;
        end
        m_und = (m_und && !clr) || und;
        m_ovf = (m_ovf && !clr) || ovf;
        m_sht = (m_sht && !clr) || sht;
    endtask

    task automatic check_outputs();
        chk_eq("we", int'(fb_we_out), int'(m_we));
        if (m_we) begin
            chk_eq("addr", int'(fb_addr_out), m_addr);
            chk_eq("data", int'(fb_data_out), m_data);
        end
        chk_eq("bank", int'(fb_bank_out), m_bank);
        chk_eq("frame_done", int'(frame_done_out), int'(m_fd));
        chk_eq("line", int'(line_out), m_y);
        chk_eq("err_underrun", int'(err_underrun_out), int'(m_und));
        chk_eq("err_overflow", int'(err_overflow_out), int'(m_ovf));
        chk_eq("err_short_frame", int'(err_short_frame_out), int'(m_sht));
    endtask

    // One clock with the given inputs, then model update and output check.
    task automatic step(input bit v, input int s, input bit h, input bit vb,
                        input int bgp, input bit clr);
        pix_valid_in = v;
        pix_shade_in = 2'(s);
        hblank_in    = h;
        vblank_in    = vb;
        bgp_in       = 8'(bgp);
        clr_err_in   = clr;
        @(posedge clk_in);
        model_clock(v, s, h, vb, bgp, clr);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    // n pixels with occasional idle gaps; shade < 0 means random shade.
    task automatic send_pixels(input int n, input int shade, input int bgp);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 15) == 0) idle(1);
            step(1, (shade < 0) ? int'($urandom_range(0, 3)) : shade, 0, 0, bgp, 0);
        end
    endtask

    task automatic send_line(input int n);
        send_pixels(n, -1, int'($urandom_range(0, 255)));
        step(0, 0, 1, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk_in);
        #1;
        check_outputs();
        @(negedge clk_in);
        rst_n_in = 1'b1;

        // Not yet synchronised: pixels and hblank ignored
        send_pixels(5, -1, 8'hE4);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);

        // Frame A: first line shade 1 through 8'hE4, then full random frame
        send_pixels(W, 1, 8'hE4);
        step(0, 0, 1, 0, 0, 0);
        for (int y = 1; y < H; y++) send_line(W);
        idle(2);
        step(0, 0, 0, 1, 0, 0);

        // Frame B: final pixel coincides with hblank and vblank
        for (int y = 0; y < H - 1; y++) send_line(W);
        send_pixels(W - 1, -1, int'($urandom_range(0, 255)));
        step(1, int'($urandom_range(0, 3)), 1, 1, int'($urandom_range(0, 255)), 0);
        idle(2);

        // Frame C: underrun, overflow, short frame, error clears
        send_line(100);
        send_pixels(W, -1, 8'h1B);
        step(1, 2, 0, 0, 8'h1B, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        send_pixels(W, -1, 8'h93);
        step(1, 3, 0, 0, 8'h93, 1);
        step(0, 0, 1, 0, 0, 0);
        for (int y = 3; y < 10; y++) send_line(W);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        send_line(W - 1);
        send_pixels(W, -1, 8'h55);
        step(1, 1, 1, 1, 8'h55, 1);
        step(0, 0, 0, 0, 0, 1);

        // Random protocol traffic
        for (int i = 0; i < 4000; i++) begin
            step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 $urandom_range(0, 39) == 0, $urandom_range(0, 299) == 0,
                 int'($urandom_range(0, 255)), $urandom_range(0, 49) == 0);
        end

        // Asynchronous reset mid-line with a write pending on the outputs
        step(0, 0, 0, 1, 0, 0);
        send_pixels(20, -1, 8'hE4);
        step(1, 3, 0, 0, 8'hE4, 0);
        rst_n_in = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk_in);
        rst_n_in = 1'b1;
        send_pixels(5, -1, 8'hE4);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        send_line(W);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
